// File: rtl/llc_ctrl_regs_if.sv
// Bus bundle for llc_ctrl_regs: flag set/clear, set-sweep sequencer, DMA counter and conflict log.
// The regs block takes the slave modport; the requesting stages or the bench take the master modport.
interface llc_ctrl_regs_if #(
    parameter int NUM_FLAGS = 16,
    parameter int NUM_SRC   = 2,
    parameter int SET_W     = 9,
    parameter int ADDR_W    = 32
);
    logic [NUM_SRC-1:0][NUM_FLAGS-1:0] set_i;
    logic [NUM_SRC-1:0][NUM_FLAGS-1:0] clr_i;
    logic [NUM_FLAGS-1:0]              flags_o;
    logic [NUM_FLAGS-1:0]              flag_rise_o;

    logic                              sweep_start_i;
    logic                              sweep_mode_i;
    logic                              sweep_adv_i;
    logic                              sweep_busy_o;
    logic                              sweep_mode_o;
    logic [SET_W-1:0]                  sweep_set_o;
    logic                              sweep_done_o;

    logic                              dma_load_i;
    logic [ADDR_W-1:0]                 dma_load_addr_i;
    logic                              dma_incr_i;
    logic [ADDR_W-1:0]                 dma_addr_o;
    logic                              dma_wrap_o;

    logic [NUM_FLAGS-1:0]              conflict_o;
    logic                              conflict_clr_i;

    modport master (
        output set_i, clr_i, sweep_start_i, sweep_mode_i, sweep_adv_i,
               dma_load_i, dma_load_addr_i, dma_incr_i, conflict_clr_i,
        input  flags_o, flag_rise_o, sweep_busy_o, sweep_mode_o, sweep_set_o,
               sweep_done_o, dma_addr_o, dma_wrap_o, conflict_o
    );

    modport slave (
        input  set_i, clr_i, sweep_start_i, sweep_mode_i, sweep_adv_i,
               dma_load_i, dma_load_addr_i, dma_incr_i, conflict_clr_i,
        output flags_o, flag_rise_o, sweep_busy_o, sweep_mode_o, sweep_set_o,
               sweep_done_o, dma_addr_o, dma_wrap_o, conflict_o
    );
endinterface

// File: rtl/llc_ctrl_regs.sv
// LLC control/status register bank: prioritised set/clear flags, set-sweep sequencer, DMA address counter.
// Optional sticky collision log enabled by defining LLC_CTRL_REGS_CONFLICT_EN.
//
// state    | meaning
// ST_IDLE  | no sweep running, waiting for sweep_start_i
// ST_SWEEP | walking sets, busy high, sweep_adv_i steps the set index
// ST_DONE  | one-cycle done pulse after the last set, then back to idle
module llc_ctrl_regs #(
    parameter int                   NUM_FLAGS    = 16,
    parameter int                   NUM_SRC      = 2,
    parameter logic [NUM_FLAGS-1:0] FLAG_RST_VAL = '0,
    parameter logic [NUM_FLAGS-1:0] SET_PRIO     = '0,
    parameter int                   SETS         = 512,
    parameter int                   ADDR_W       = 32,
    parameter bit                   AUTO_SWEEP   = 1'b1,
    localparam int                  SET_W        = $clog2(SETS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_state,
    llc_ctrl_regs_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_e;

    localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

    logic [NUM_FLAGS-1:0] s_any, c_any;
    logic [NUM_FLAGS-1:0] flags_d, flags_q, rise_q;

    sweep_state_e         state_d, state_q;
    logic [SET_W-1:0]     set_d, set_q;
    logic                 mode_d, mode_q;
    logic                 busy_q, done_q;

    logic [ADDR_W-1:0]    addr_d, addr_q;
    logic                 wrap_d, wrap_q;

    // Flag update: hold when idle, collisions resolved per bit by SET_PRIO
    always_comb begin
        s_any = '0;
        c_any = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_any = s_any | bus.set_i[i];
            c_any = c_any | bus.clr_i[i];
        end
        flags_d = (flags_q & ~(s_any | c_any)) | (s_any & ~c_any) | (s_any & c_any & SET_PRIO);
    end

    always_ff @(posedge clk) begin
        if (rst || rst_state) begin
            flags_q <= FLAG_RST_VAL;
            rise_q  <= '0;
        end else begin
            flags_q <= flags_d;
            rise_q  <= flags_d & ~flags_q;
        end
    end

    always_comb begin
        state_d = state_q;
        set_d   = set_q;
        mode_d  = mode_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.sweep_start_i) begin
                    state_d = ST_SWEEP;
                    set_d   = '0;
                    mode_d  = bus.sweep_mode_i;
                end
            end
            ST_SWEEP: begin
                if (bus.sweep_adv_i) begin
                    if (set_q == LAST_SET) begin
                        state_d = ST_DONE;
                        set_d   = '0;
                    end else begin
                        set_d   = set_q + SET_W'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                set_d   = '0;
            end
        endcase
    end

    // busy/done are registered copies of the next state so they line up with state_q
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= AUTO_SWEEP ? ST_SWEEP : ST_IDLE;
            set_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= AUTO_SWEEP;
            done_q  <= 1'b0;
        end else if (rst_state) begin
            state_q <= ST_IDLE;
            set_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            set_q   <= set_d;
            mode_q  <= mode_d;
            busy_q  <= (state_d == ST_SWEEP);
            done_q  <= (state_d == ST_DONE);
        end
    end

    always_comb begin
        addr_d = addr_q;
        wrap_d = 1'b0;
        if (bus.dma_load_i) begin
            addr_d = bus.dma_load_addr_i;
        end else if (bus.dma_incr_i) begin
            addr_d = addr_q + ADDR_W'(1);
            wrap_d = &addr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rst_state) begin
            addr_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            wrap_q <= wrap_d;
        end
    end

`ifdef LLC_CTRL_REGS_CONFLICT_EN
    logic [NUM_FLAGS-1:0] conflict_d, conflict_q;

    // A fresh collision beats a clear arriving in the same cycle
    always_comb begin
        conflict_d = (bus.conflict_clr_i ? '0 : conflict_q) | (s_any & c_any);
    end

    always_ff @(posedge clk) begin
        if (rst || rst_state) begin
            conflict_q <= '0;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign bus.conflict_o = conflict_q;
`else
    logic unused_conflict_clr;
    assign unused_conflict_clr = bus.conflict_clr_i;
    assign bus.conflict_o      = '0;
`endif

    assign bus.flags_o      = flags_q;
    assign bus.flag_rise_o  = rise_q;
    assign bus.sweep_busy_o = busy_q;
    assign bus.sweep_mode_o = mode_q;
    assign bus.sweep_set_o  = set_q;
    assign bus.sweep_done_o = done_q;
    assign bus.dma_addr_o   = addr_q;
    assign bus.dma_wrap_o   = wrap_q;

endmodule

// File: tb/tb_llc_ctrl_regs.sv
// Directed bench for llc_ctrl_regs: reset, flag priority, sweep, soft reset, DMA counter, conflict log.
// Conflict expectations follow LLC_CTRL_REGS_CONFLICT_EN.
module tb_llc_ctrl_regs;
    localparam int NUM_FLAGS = 16;
    localparam int NUM_SRC   = 3;
    localparam int SETS      = 4;
    localparam int SET_W     = 2;
    localparam int ADDR_W    = 32;

`ifdef LLC_CTRL_REGS_CONFLICT_EN
    localparam bit CONF_EN = 1'b1;
`else
    localparam bit CONF_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic rst_state;
    int   n_checks = 0;
    int   n_fail   = 0;

    llc_ctrl_regs_if #(.NUM_FLAGS(NUM_FLAGS), .NUM_SRC(NUM_SRC), .SET_W(SET_W), .ADDR_W(ADDR_W)) bus ();

    llc_ctrl_regs #(
        .NUM_FLAGS    (NUM_FLAGS),
        .NUM_SRC      (NUM_SRC),
        .FLAG_RST_VAL (16'h0001),
        .SET_PRIO     (16'h0008),
        .SETS         (SETS),
        .ADDR_W       (ADDR_W),
        .AUTO_SWEEP   (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_state (rst_state),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst                 = 1'b1;
        rst_state           = 1'b0;
        bus.set_i           = '0;
        bus.clr_i           = '0;
        bus.sweep_start_i   = 1'b0;
        bus.sweep_mode_i    = 1'b0;
        bus.sweep_adv_i     = 1'b0;
        bus.dma_load_i      = 1'b0;
        bus.dma_load_addr_i = '0;
        bus.dma_incr_i      = 1'b0;
        bus.conflict_clr_i  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        check("rst_flags", bus.flags_o, 32'h0001);
        check("rst_rise", bus.flag_rise_o, 32'h0);
        check("rst_busy", bus.sweep_busy_o, 32'h1);
        check("rst_set", bus.sweep_set_o, 32'h0);
        check("rst_mode", bus.sweep_mode_o, 32'h0);
        check("rst_done", bus.sweep_done_o, 32'h0);
        check("rst_dma", bus.dma_addr_o, 32'h0);
        check("rst_wrap", bus.dma_wrap_o, 32'h0);
        check("rst_conflict", bus.conflict_o, 32'h0);

        // finish the automatic reset sweep
        bus.sweep_adv_i = 1'b1;
        tick(); check("auto_set1", bus.sweep_set_o, 32'd1);
        tick(); check("auto_set2", bus.sweep_set_o, 32'd2);
        tick(); check("auto_set3", bus.sweep_set_o, 32'd3);
        tick();
        check("auto_done", bus.sweep_done_o, 32'h1);
        check("auto_done_busy", bus.sweep_busy_o, 32'h0);
        check("auto_done_set", bus.sweep_set_o, 32'h0);
        bus.sweep_adv_i = 1'b0;
        tick();
        check("auto_idle_done", bus.sweep_done_o, 32'h0);
        check("auto_idle_busy", bus.sweep_busy_o, 32'h0);

        // set/clear collision on flags 3 (set wins) and 4 (clear wins)
        bus.set_i[0] = 16'h0018;
        bus.clr_i[1] = 16'h0018;
        tick();
        check("coll_flags", bus.flags_o, 32'h0009);
        check("coll_rise", bus.flag_rise_o, 32'h0008);
        check("coll_conflict", bus.conflict_o, CONF_EN ? 32'h0018 : 32'h0);
        bus.set_i = '0;
        bus.clr_i = '0;
        tick();
        check("coll_rise_gone", bus.flag_rise_o, 32'h0);
        check("coll_flags_hold", bus.flags_o, 32'h0009);
        check("conflict_sticky", bus.conflict_o, CONF_EN ? 32'h0018 : 32'h0);
        bus.conflict_clr_i = 1'b1;
        tick();
        check("conflict_clr", bus.conflict_o, 32'h0);
        bus.set_i[2] = 16'h0020;
        bus.clr_i[0] = 16'h0020;
        tick();
        check("conflict_clr_vs_new", bus.conflict_o, CONF_EN ? 32'h0020 : 32'h0);
        check("flag5_clear_wins", bus.flags_o, 32'h0009);
        bus.conflict_clr_i = 1'b0;
        bus.set_i = '0;
        bus.clr_i = '0;

        // clear from source 2 only, held for 5 cycles
        bus.clr_i[2] = 16'h0008;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("src2_clr_flags", bus.flags_o, 32'h0001);
            check("src2_clr_rise", bus.flag_rise_o, 32'h0);
        end
        bus.clr_i = '0;

        // set held 3 cycles gives a single rise pulse
        bus.set_i[1] = 16'h0400;
        tick();
        check("set_hold_flags", bus.flags_o, 32'h0401);
        check("set_hold_rise", bus.flag_rise_o, 32'h0400);
        tick();
        check("set_hold_rise2", bus.flag_rise_o, 32'h0);
        tick();
        check("set_hold_rise3", bus.flag_rise_o, 32'h0);
        check("set_hold_flags3", bus.flags_o, 32'h0401);
        bus.set_i = '0;

        // flush sweep with a start issued mid-sweep
        bus.sweep_start_i = 1'b1;
        bus.sweep_mode_i  = 1'b1;
        tick();
        check("flush_busy", bus.sweep_busy_o, 32'h1);
        check("flush_mode", bus.sweep_mode_o, 32'h1);
        check("flush_set0", bus.sweep_set_o, 32'd0);
        bus.sweep_start_i = 1'b0;
        bus.sweep_mode_i  = 1'b0;
        bus.sweep_adv_i   = 1'b1;
        tick();
        check("flush_set1", bus.sweep_set_o, 32'd1);
        bus.sweep_start_i = 1'b1;
        tick();
        check("flush_set2", bus.sweep_set_o, 32'd2);
        check("flush_mode_kept", bus.sweep_mode_o, 32'h1);
        bus.sweep_start_i = 1'b0;
        tick();
        check("flush_set3", bus.sweep_set_o, 32'd3);
        check("flush_busy3", bus.sweep_busy_o, 32'h1);
        tick();
        check("flush_done", bus.sweep_done_o, 32'h1);
        check("flush_done_busy", bus.sweep_busy_o, 32'h0);
        check("flush_done_set", bus.sweep_set_o, 32'h0);
        bus.sweep_adv_i   = 1'b0;
        bus.sweep_start_i = 1'b1;
        tick();
        check("done_start_ignored", bus.sweep_busy_o, 32'h0);
        check("done_pulse_one", bus.sweep_done_o, 32'h0);
        bus.sweep_start_i = 1'b0;
        tick();
        check("idle_after_done", bus.sweep_busy_o, 32'h0);

        // soft reset mid-sweep at set 2
        bus.sweep_start_i = 1'b1;
        bus.sweep_mode_i  = 1'b1;
        tick();
        bus.sweep_start_i = 1'b0;
        bus.sweep_mode_i  = 1'b0;
        bus.sweep_adv_i   = 1'b1;
        tick();
        tick();
        check("pre_rs_set", bus.sweep_set_o, 32'd2);
        rst_state = 1'b1;
        tick();
        check("rs_busy", bus.sweep_busy_o, 32'h0);
        check("rs_set", bus.sweep_set_o, 32'h0);
        check("rs_mode", bus.sweep_mode_o, 32'h0);
        check("rs_flags", bus.flags_o, 32'h0001);
        check("rs_conflict", bus.conflict_o, 32'h0);
        check("rs_rise", bus.flag_rise_o, 32'h0);
        rst_state       = 1'b0;
        bus.sweep_adv_i = 1'b0;
        tick();
        check("rs_stays_idle", bus.sweep_busy_o, 32'h0);

        // DMA counter wrap and load priority
        bus.dma_load_i      = 1'b1;
        bus.dma_load_addr_i = 32'hFFFF_FFFE;
        tick();
        check("dma_load", bus.dma_addr_o, 32'hFFFF_FFFE);
        bus.dma_load_i = 1'b0;
        bus.dma_incr_i = 1'b1;
        tick();
        check("dma_incr1", bus.dma_addr_o, 32'hFFFF_FFFF);
        check("dma_wrap_none", bus.dma_wrap_o, 32'h0);
        tick();
        check("dma_incr2", bus.dma_addr_o, 32'h0);
        check("dma_wrap", bus.dma_wrap_o, 32'h1);
        bus.dma_incr_i = 1'b0;
        tick();
        check("dma_wrap_pulse", bus.dma_wrap_o, 32'h0);
        check("dma_hold", bus.dma_addr_o, 32'h0);
        bus.dma_load_i      = 1'b1;
        bus.dma_incr_i      = 1'b1;
        bus.dma_load_addr_i = 32'h0000_0100;
        tick();
        check("dma_load_incr", bus.dma_addr_o, 32'h0000_0100);
        bus.dma_load_addr_i = 32'hFFFF_FFFF;
        tick();
        bus.dma_load_i = 1'b0;
        bus.dma_incr_i = 1'b0;
        tick();
        check("dma_load_prio_nowrap", bus.dma_wrap_o, 32'h0);
        check("dma_load_ones", bus.dma_addr_o, 32'hFFFF_FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/llc_ctrl_regs.md
# llc_ctrl_regs

Parametrised control/status register bank for the LLC pipeline. It generalises the fixed set of per-purpose stall/pending flops into a vector of NUM_FLAGS set/clear flags, driven by NUM_SRC independent requester stages with per-flag priority. It also provides a set-sweep sequencer for reset/flush walks and a loadable DMA address counter. It sits between the LLC decoder/process/update stages and the datapath, and all outputs are registered.

## Interface
Parameters:
- NUM_FLAGS, 16, number of set/clear flags
- NUM_SRC, 2, number of requester stages (e.g. decoder, process)
- FLAG_RST_VAL, '0, NUM_FLAGS-bit value loaded on rst and rst_state
- SET_PRIO, '0, NUM_FLAGS-bit mask; bit=1 means set wins over clear on collision, bit=0 means clear wins
- SETS, 512, number of LLC sets walked by the sweeper (power of two, >=2); SET_W = $clog2(SETS)
- ADDR_W, 32, DMA address width
- AUTO_SWEEP, 1, 1 = enter reset sweep automatically after rst

Ports:
- clk  in  1  clock
- rst  in  1  reset; **synchronous, active-high**
- rst_state  in  1  soft clear; same effect as rst except AUTO_SWEEP is not honoured
- set_i  in  NUM_SRC x NUM_FLAGS  per-source set requests
- clr_i  in  NUM_SRC x NUM_FLAGS  per-source clear requests
- flags_o  out  NUM_FLAGS  flag state
- flag_rise_o  out  NUM_FLAGS  one-cycle pulse on a 0->1 flag transition
- sweep_start_i  in  1  start sweep
- sweep_mode_i  in  1  0 = reset sweep, 1 = flush sweep
- sweep_adv_i  in  1  current set processed; advance
- sweep_busy_o  out  1  sweep in progress (stall upstream)
- sweep_mode_o  out  1  latched mode
- sweep_set_o  out  SET_W  current set index
- sweep_done_o  out  1  one-cycle pulse after the last set
- dma_load_i  in  1  load DMA address
- dma_load_addr_i  in  ADDR_W  load value
- dma_incr_i  in  1  increment DMA address
- dma_addr_o  out  ADDR_W  DMA address
- dma_wrap_o  out  1  one-cycle pulse when an increment wraps to 0
- conflict_o  out  NUM_FLAGS  sticky set/clear collision log (see Configuration)
- conflict_clr_i  in  1  clear conflict_o

## Operation
- Per flag f: S = OR of set_i[*][f]; C = OR of clr_i[*][f].
- Next value of flag f: rst/rst_state -> FLAG_RST_VAL[f]; S&C -> SET_PRIO[f]; S -> 1; C -> 0; otherwise hold.
- flag_rise_o[f] = registered (next & ~current). It is 0 on rst/rst_state cycles.
- Sweep FSM has three states: IDLE, SWEEP, DONE.
  - IDLE: on sweep_start_i go to SWEEP, with sweep_set_o=0 and sweep_mode_o=sweep_mode_i.
  - SWEEP: sweep_busy_o=1. sweep_adv_i increments sweep_set_o. sweep_adv_i with sweep_set_o==SETS-1 goes to DONE and sweep_set_o wraps to 0. sweep_start_i is ignored.
  - DONE: sweep_done_o=1 and sweep_busy_o=0 for exactly one cycle, then IDLE. A start here is ignored.
- Leaving rst with AUTO_SWEEP=1: FSM is in SWEEP, mode 0, set 0. With AUTO_SWEEP=0 the FSM is in IDLE.
- rst_state in any state: IDLE, set 0, mode 0.
- DMA counter:
  - dma_load_i loads dma_load_addr_i. dma_incr_i adds 1 modulo 2^ADDR_W.
  - Load has priority over incr; load+incr in the same cycle loads only.
  - dma_wrap_o pulses on an incr from all-ones.
- Reset values: flags_o=FLAG_RST_VAL, flag_rise_o=0, sweep_set_o=0, sweep_mode_o=0, sweep_done_o=0, dma_addr_o=0, dma_wrap_o=0, conflict_o=0. sweep_busy_o=AUTO_SWEEP after rst and 0 after rst_state.

## Timing
- All updates take effect on the clk edge after the request; outputs are registered with 1-cycle latency and no combinational input-to-output paths.
- Requests are level-sampled each cycle. Asserting a set or clear for N cycles behaves the same as asserting it for 1 cycle.
- A sweep of SETS sets, with sweep_adv_i held high, takes SETS cycles in SWEEP plus 1 cycle in DONE.
- rst and rst_state override every other input in the same cycle, including mid-sweep.

## Configuration
- LLC_CTRL_REGS_CONFLICT_EN defined:
  - conflict_o[f] is set the cycle after S&C on flag f and stays set until conflict_clr_i, rst or rst_state.
  - A new collision in the same cycle as conflict_clr_i sets the bit (set wins).
- LLC_CTRL_REGS_CONFLICT_EN undefined: conflict_o is tied to 0, conflict_clr_i is ignored, and no storage is instantiated.

## Test plan
- Reset with FLAG_RST_VAL=16'h0001, AUTO_SWEEP=1 -> flags_o=16'h0001, sweep_busy_o=1, sweep_set_o=0, dma_addr_o=0.
- SET_PRIO[3]=1, SET_PRIO[4]=0; flags 3 and 4 start at 0; set_i[0] and clr_i[1] on flags 3 and 4 together -> next cycle flag3=1, flag4=0, flag_rise_o[3]=1 for 1 cycle, conflict_o=16'h0018 (macro on) or 0 (macro off).
- SETS=4, flush sweep (mode 1), sweep_adv_i held -> sweep_set_o goes 0,1,2,3; then sweep_done_o=1 for one cycle; then IDLE with busy=0. A start issued mid-sweep is ignored.
- rst_state asserted at sweep_set_o=2 -> next cycle IDLE, set 0, flags_o=FLAG_RST_VAL, conflict_o=0.
- dma_load_i with 32'hFFFF_FFFE, then two incr -> dma_addr_o goes FFFF_FFFF, then 0 with dma_wrap_o=1. Load and incr together with 32'h100 -> dma_addr_o=32'h100.
- NUM_SRC=3, clr_i only from source 2 on a set flag -> flag clears in 1 cycle; holding clr_i 5 cycles leaves it at 0 with no pulses.
